// File: rtl/ble_tx_serializer_pkg.sv
// Shared constants and state encoding for the BLE TX serializer.
// Default widths are mirrored by the module parameters of the top level.
package ble_tx_serializer_pkg;

  localparam int BLE_DATA    = 32;
  localparam int BLE_SIZE_W  = 17;
  localparam int FIFO_RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ble_tx_bit_buffer.sv
// Two-word bit buffer: an LSB-first shift register backed by one holding register.
// The holding word slides into the shift register on the edge its last bit leaves.
module ble_tx_bit_buffer
  import ble_tx_serializer_pkg::*;
#(
  parameter int DATA = BLE_DATA
) (
  input  logic            clk_read_i,
  input  logic            reset_ni,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic [DATA-1:0] word_i,
  input  logic            pop_i,
  output logic            bit_o,
  output logic            valid_o,
  output logic            accept_o,
  output logic            empty_o
);

  localparam int CNT_W = $clog2(DATA + 1);

  logic [DATA-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic [DATA-1:0]  hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             exhaust;
  logic             shift_free;

  assign exhaust    = pop_i && (shift_cnt_q == CNT_W'(1));
  assign shift_free = (shift_cnt_q == '0) || exhaust;
  assign bit_o      = shift_q[0];
  assign valid_o    = (shift_cnt_q != '0);
  assign accept_o   = !hold_vld_q || shift_free;
  assign empty_o    = (shift_cnt_q == '0) && !hold_vld_q;

  always_comb begin
    shift_d     = shift_q;
    shift_cnt_d = shift_cnt_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;

    if (pop_i && (shift_cnt_q > CNT_W'(1))) begin
      shift_d     = shift_q >> 1;
      shift_cnt_d = shift_cnt_q - CNT_W'(1);
    end

    if (shift_free) begin
      if (hold_vld_q) begin
        shift_d     = hold_q;
        shift_cnt_d = CNT_W'(DATA);
        hold_vld_d  = load_i;
        if (load_i) hold_d = word_i;
      end else if (load_i) begin
        shift_d     = word_i;
        shift_cnt_d = CNT_W'(DATA);
      end else begin
        shift_d     = '0;
        shift_cnt_d = '0;
      end
    end else if (load_i) begin
      hold_d     = word_i;
      hold_vld_d = 1'b1;
    end

    if (clear_i) begin
      shift_d     = '0;
      shift_cnt_d = '0;
      hold_d      = '0;
      hold_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_read_i or negedge reset_ni) begin
    if (!reset_ni) begin
      shift_q     <= '0;
      shift_cnt_q <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      shift_cnt_q <= shift_cnt_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
    end
  end

endmodule

// File: rtl/ble_tx_serializer.sv
// Streams packets from the shared-memory FIFO as serial bits to the BLE TX chain.
// Owns the packet FSM, bit/word counters and the FIFO read strobe.
module ble_tx_serializer
  import ble_tx_serializer_pkg::*;
#(
  parameter int DATA   = BLE_DATA,
  parameter int SIZE_W = BLE_SIZE_W
) (
  input  logic              clk_read_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [SIZE_W-1:0] data_size_i,
  input  logic              fifo_empty_i,
  output logic              re_o,
  input  logic [DATA-1:0]   data_in_i,
  output logic              bit_out_o,
  output logic              bit_valid_o,
  input  logic              bit_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              underrun_o
);

  state_e                 state_q, state_d;
  logic [SIZE_W-1:0]      bits_left_q, bits_left_d;
  logic [SIZE_W-1:0]      words_left_q, words_left_d;
  logic                   underrun_q, underrun_d;
  logic [FIFO_RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [SIZE_W:0]        size_round;
  logic [SIZE_W-1:0]      words_calc;
  logic                   in_flight;
  logic                   buf_clear, buf_load, buf_bit, buf_valid, buf_accept, buf_empty;
  logic                   xfer;

  // Word count is ceil(data_size / DATA), widened by one bit to avoid overflow.
  assign size_round = {1'b0, data_size_i} + (SIZE_W+1)'(DATA - 1);
  assign words_calc = SIZE_W'(size_round / (SIZE_W+1)'(DATA));

  assign in_flight   = |rd_pipe_q;
  assign buf_load    = rd_pipe_q[FIFO_RD_LAT-1] && (state_q == ST_RUN);
  assign re_o        = (state_q == ST_RUN) && (words_left_q != '0) && !fifo_empty_i
                       && !in_flight && buf_accept;
  assign bit_valid_o = (state_q == ST_RUN) && buf_valid;
  assign bit_out_o   = buf_bit;
  assign xfer        = bit_valid_o && bit_ready_i;
  assign busy_o      = (state_q == ST_RUN);
  assign done_o      = (state_q == ST_DONE);
  assign underrun_o  = underrun_q;

  always_comb begin
    state_d      = state_q;
    bits_left_d  = bits_left_q;
    words_left_d = words_left_q;
    underrun_d   = underrun_q;
    rd_pipe_d    = FIFO_RD_LAT'({rd_pipe_q, re_o});
    buf_clear    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          underrun_d = 1'b0;
          if (data_size_i == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d      = ST_RUN;
            bits_left_d  = data_size_i;
            words_left_d = words_calc;
          end
        end
      end
      ST_RUN: begin
        if (re_o) words_left_d = words_left_q - SIZE_W'(1);
        if (bits_left_q != '0 && buf_empty && !in_flight && fifo_empty_i) underrun_d = 1'b1;
        if (xfer) begin
          bits_left_d = bits_left_q - SIZE_W'(1);
          // Last bit: drop any unsent tail of a partial final word.
          if (bits_left_q == SIZE_W'(1)) begin
            state_d      = ST_DONE;
            buf_clear    = 1'b1;
            words_left_d = '0;
            rd_pipe_d    = '0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort_i) begin
      state_d      = ST_IDLE;
      bits_left_d  = '0;
      words_left_d = '0;
      underrun_d   = underrun_q;
      rd_pipe_d    = '0;
      buf_clear    = 1'b1;
    end
  end

  always_ff @(posedge clk_read_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= ST_IDLE;
      bits_left_q  <= '0;
      words_left_q <= '0;
      underrun_q   <= 1'b0;
      rd_pipe_q    <= '0;
    end else begin
      state_q      <= state_d;
      bits_left_q  <= bits_left_d;
      words_left_q <= words_left_d;
      underrun_q   <= underrun_d;
      rd_pipe_q    <= rd_pipe_d;
    end
  end

  ble_tx_bit_buffer #(.DATA(DATA)) u_bit_buffer (
    .clk_read_i (clk_read_i),
    .reset_ni   (reset_ni),
    .clear_i    (buf_clear),
    .load_i     (buf_load),
    .word_i     (data_in_i),
    .pop_i      (xfer),
    .bit_o      (buf_bit),
    .valid_o    (buf_valid),
    .accept_o   (buf_accept),
    .empty_o    (buf_empty)
  );

endmodule

// File: tb/tb_ble_tx_serializer.sv
// Directed bench for ble_tx_serializer with a one-cycle-latency FIFO model.
// Each scenario task drives its own stimulus and checks hand-computed results.
module tb_ble_tx_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort, fifo_empty, re, bit_out, bit_valid, bit_ready;
  logic        busy, done, underrun;
  logic [16:0] data_size;
  logic [31:0] data_in;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] fifo_mem [0:7];
  int  rd_ptr, rd_idx, fifo_level;
  bit  rd_pending;

  int  re_cycles[$];
  int  xfer_cycles[$];
  bit  got_bits[$];
  int  done_cycles[$];
  int  busy_cnt, stable_err, first_valid, t_start;
  bit  busy_t1, underrun_t1, busy_at_done, timed_out;
  bit  prev_valid, prev_ready, prev_bit;

  ble_tx_serializer dut (
    .clk_read_i  (clk),
    .reset_ni    (reset_n),
    .start_i     (start),
    .abort_i     (abort),
    .data_size_i (data_size),
    .fifo_empty_i(fifo_empty),
    .re_o        (re),
    .data_in_i   (data_in),
    .bit_out_o   (bit_out),
    .bit_valid_o (bit_valid),
    .bit_ready_i (bit_ready),
    .busy_o      (busy),
    .done_o      (done),
    .underrun_o  (underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    data_in    = rd_pending ? fifo_mem[rd_idx] : 32'hDEADBEEF;
    rd_pending = 1'b0;
    fifo_empty = (rd_ptr >= fifo_level);
  endtask

  task automatic observe();
    #1;
    if (re === 1'b1) begin
      re_cycles.push_back(cyc);
      rd_idx = rd_ptr;
      rd_ptr++;
      rd_pending = 1'b1;
    end
    if (bit_valid === 1'b1 && bit_ready === 1'b1) begin
      got_bits.push_back(bit_out);
      xfer_cycles.push_back(cyc);
    end
    if (bit_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    if (done === 1'b1) begin
      done_cycles.push_back(cyc);
      busy_at_done = busy;
    end
    if (busy === 1'b1) busy_cnt++;
    if (prev_valid && !prev_ready && (bit_valid !== 1'b1 || bit_out !== prev_bit)) stable_err++;
    prev_valid = bit_valid;
    prev_ready = bit_ready;
    prev_bit   = bit_out;
  endtask

  task automatic clear_obs();
    re_cycles.delete();
    xfer_cycles.delete();
    got_bits.delete();
    done_cycles.delete();
    busy_cnt = 0; stable_err = 0; first_valid = -1;
    busy_at_done = 1'b0; timed_out = 1'b0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_bit = 1'b0;
  endtask

  task automatic start_packet(input int size);
    advance();
    start = 1'b1;
    data_size = 17'(size);
    observe();
    t_start = cyc;
    advance();
    start = 1'b0;
    observe();
    busy_t1     = busy;
    underrun_t1 = underrun;
  endtask

  task automatic run_to_done(input int budget, input bit toggle);
    int n;
    n = 0;
    while (done_cycles.size() == 0 && n < budget) begin
      advance();
      if (toggle) bit_ready = (cyc % 2 == 0);
      observe();
      n++;
    end
    timed_out = (done_cycles.size() == 0);
    bit_ready = 1'b1;
  endtask

  function automatic logic [127:0] packed_bits();
    logic [127:0] v;
    v = '0;
    foreach (got_bits[i]) if (i < 128) v[i] = got_bits[i];
    return v;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b1; abort = 1'b0; data_size = 17'd64; bit_ready = 1'b1;
    rd_ptr = 0; fifo_level = 2; fifo_empty = 1'b0; data_in = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (re !== 1'b0)        begin errors++; $display("[TB] FAIL reset_re got=%b exp=0", re); end
    checks++; if (bit_out !== 1'b0)   begin errors++; $display("[TB] FAIL reset_bit_out got=%b exp=0", bit_out); end
    checks++; if (bit_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_bit_valid got=%b exp=0", bit_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (underrun !== 1'b0)  begin errors++; $display("[TB] FAIL reset_underrun got=%b exp=0", underrun); end
    start = 1'b0;
    fifo_level = 0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_full_words();
    logic [127:0] v;
    rd_ptr = 0; fifo_mem[0] = 32'hA5A5A5A5; fifo_mem[1] = 32'h0000FFFF; fifo_level = 2;
    bit_ready = 1'b1;
    clear_obs();
    start_packet(64);
    run_to_done(200, 1'b0);
    v = packed_bits();
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL full_timeout got=no_done exp=done"); end
    checks++; if (busy_t1 !== 1'b1) begin errors++; $display("[TB] FAIL full_busy_t1 got=%b exp=1", busy_t1); end
    checks++; if (re_cycles.size() != 2) begin errors++; $display("[TB] FAIL full_re_count got=%0d exp=2", re_cycles.size()); end
    if (re_cycles.size() == 2) begin
      checks++; if (re_cycles[0] != t_start + 1 || re_cycles[1] != t_start + 3) begin
        errors++; $display("[TB] FAIL full_re_timing got=T+%0d,T+%0d exp=T+1,T+3", re_cycles[0] - t_start, re_cycles[1] - t_start);
      end
    end
    checks++; if (first_valid != t_start + 3) begin errors++; $display("[TB] FAIL full_first_valid got=T+%0d exp=T+3", first_valid - t_start); end
    checks++; if (got_bits.size() != 64) begin errors++; $display("[TB] FAIL full_bit_count got=%0d exp=64", got_bits.size()); end
    checks++; if (v[63:0] !== 64'h0000FFFF_A5A5A5A5) begin errors++; $display("[TB] FAIL full_bits got=%h exp=0000ffffa5a5a5a5", v[63:0]); end
    if (xfer_cycles.size() == 64 && done_cycles.size() == 1) begin
      checks++; if (xfer_cycles[63] - xfer_cycles[0] != 63) begin errors++; $display("[TB] FAIL full_contiguous got=%0d exp=63", xfer_cycles[63] - xfer_cycles[0]); end
      checks++; if (done_cycles[0] != xfer_cycles[63] + 1) begin errors++; $display("[TB] FAIL full_done_cycle got=%0d exp=%0d", done_cycles[0], xfer_cycles[63] + 1); end
    end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("[TB] FAIL full_busy_in_done got=%b exp=0", busy_at_done); end
    advance(); observe();
    checks++; if (done !== 1'b0 || done_cycles.size() != 1) begin errors++; $display("[TB] FAIL full_done_pulse got=%b/%0d exp=0/1", done, done_cycles.size()); end
  endtask

  task automatic test_partial_word();
    logic [127:0] v;
    rd_ptr = 0; fifo_mem[0] = 32'hFFFFFFFF; fifo_mem[1] = 32'h000000F0; fifo_level = 2;
    clear_obs();
    start_packet(40);
    run_to_done(200, 1'b0);
    v = packed_bits();
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL partial_timeout got=no_done exp=done"); end
    checks++; if (got_bits.size() != 40) begin errors++; $display("[TB] FAIL partial_bit_count got=%0d exp=40", got_bits.size()); end
    checks++; if (v[39:0] !== 40'hF0_FFFFFFFF) begin errors++; $display("[TB] FAIL partial_bits got=%h exp=f0ffffffff", v[39:0]); end
    checks++; if (re_cycles.size() != 2) begin errors++; $display("[TB] FAIL partial_re_count got=%0d exp=2", re_cycles.size()); end
    checks++; if (done_cycles.size() != 1) begin errors++; $display("[TB] FAIL partial_done got=%0d exp=1", done_cycles.size()); end
  endtask

  task automatic test_backpressure();
    logic [127:0] v;
    rd_ptr = 0; fifo_level = 3;
    fifo_mem[0] = 32'h12345678; fifo_mem[1] = 32'h9ABCDEF0; fifo_mem[2] = 32'h0F0F3C3C;
    clear_obs();
    start_packet(96);
    run_to_done(600, 1'b1);
    v = packed_bits();
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL bp_timeout got=no_done exp=done"); end
    checks++; if (stable_err != 0) begin errors++; $display("[TB] FAIL bp_stability got=%0d exp=0", stable_err); end
    checks++; if (got_bits.size() != 96) begin errors++; $display("[TB] FAIL bp_bit_count got=%0d exp=96", got_bits.size()); end
    checks++; if (v[95:0] !== 96'h0F0F3C3C_9ABCDEF0_12345678) begin errors++; $display("[TB] FAIL bp_bits got=%h exp=0f0f3c3c9abcdef012345678", v[95:0]); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL bp_underrun got=%b exp=0", underrun); end
  endtask

  task automatic test_underrun();
    logic [127:0] v;
    int n;
    rd_ptr = 0; fifo_mem[0] = 32'hDEADBEEF; fifo_mem[1] = 32'h13579BDF; fifo_level = 1;
    clear_obs();
    start_packet(64);
    n = 0;
    while (got_bits.size() < 32 && n < 100) begin advance(); observe(); n++; end
    repeat (4) begin advance(); observe(); end
    checks++; if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL ur_set got=%b exp=1", underrun); end
    checks++; if (bit_valid !== 1'b0) begin errors++; $display("[TB] FAIL ur_valid_low got=%b exp=0", bit_valid); end
    checks++; if (got_bits.size() != 32) begin errors++; $display("[TB] FAIL ur_stall_bits got=%0d exp=32", got_bits.size()); end
    fifo_level = 2;
    run_to_done(200, 1'b0);
    v = packed_bits();
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL ur_timeout got=no_done exp=done"); end
    checks++; if (v[63:0] !== 64'h13579BDF_DEADBEEF || got_bits.size() != 64) begin
      errors++; $display("[TB] FAIL ur_bits got=%h/%0d exp=13579bdfdeadbeef/64", v[63:0], got_bits.size());
    end
    advance(); observe();
    checks++; if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL ur_sticky got=%b exp=1", underrun); end
    clear_obs();
    start_packet(0);
    checks++; if (underrun_t1 !== 1'b0) begin errors++; $display("[TB] FAIL ur_clear_on_start got=%b exp=0", underrun_t1); end
    advance(); observe();
  endtask

  task automatic test_abort();
    logic [127:0] v;
    int n;
    rd_ptr = 0; fifo_mem[0] = 32'h3C3C3C3C; fifo_mem[1] = 32'h55AA55AA; fifo_level = 2;
    clear_obs();
    start_packet(64);
    n = 0;
    while (got_bits.size() < 10 && n < 100) begin advance(); observe(); n++; end
    advance(); abort = 1'b1; observe();
    advance(); abort = 1'b0; observe();
    checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (bit_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid got=%b exp=0", bit_valid); end
    repeat (5) begin advance(); observe(); end
    checks++; if (done_cycles.size() != 0) begin errors++; $display("[TB] FAIL abort_no_done got=%0d exp=0", done_cycles.size()); end
    rd_ptr = 0; fifo_mem[0] = 32'hC0FFEE11; fifo_level = 1;
    clear_obs();
    start_packet(32);
    run_to_done(200, 1'b0);
    v = packed_bits();
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL abort_next_timeout got=no_done exp=done"); end
    checks++; if (v[31:0] !== 32'hC0FFEE11 || got_bits.size() != 32) begin
      errors++; $display("[TB] FAIL abort_next_bits got=%h/%0d exp=c0ffee11/32", v[31:0], got_bits.size());
    end
    checks++; if (re_cycles.size() != 1) begin errors++; $display("[TB] FAIL abort_next_re got=%0d exp=1", re_cycles.size()); end
  endtask

  task automatic test_zero_size();
    rd_ptr = 0; fifo_mem[0] = 32'h11111111; fifo_level = 1;
    clear_obs();
    start_packet(0);
    repeat (3) begin advance(); observe(); end
    checks++; if (re_cycles.size() != 0) begin errors++; $display("[TB] FAIL zero_re got=%0d exp=0", re_cycles.size()); end
    checks++; if (done_cycles.size() != 1 || (done_cycles.size() == 1 && done_cycles[0] != t_start + 1)) begin
      errors++; $display("[TB] FAIL zero_done got=%0d pulses exp=1 at T+1", done_cycles.size());
    end
    checks++; if (busy_cnt != 0) begin errors++; $display("[TB] FAIL zero_busy got=%0d exp=0", busy_cnt); end
  endtask

  initial begin
    rd_pending = 1'b0;
    rd_idx = 0;
    test_reset();
    test_full_words();
    test_partial_word();
    test_backpressure();
    test_underrun();
    test_abort();
    test_zero_size();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
